complex_mse_stream: RTL

Parametrised successor to the single-shot complex mean-square unit. Streams complex samples y and y_hat, forms e = y − y_hat and the complex square e², accumulates over a window of N = 2^L samples, then outputs the mean. The squarer is internal and pipelined, so there is no vendor IP. Adds back-to-back (continuous) windows, a synchronous abort, input back-pressure, and guard-bit accumulation.

---
 rtl/cms_pkg.sv | 32 +++
 rtl/complex_square_pipe.sv | 57 +++++
 rtl/complex_mse_stream.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/cms_pkg.sv
// Shared types and width helpers for the streaming complex MSE unit.
// CMS_ROUND_EN widens the accumulator by one bit for the rounding addend.
package cms_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  // {imag, real}: field index times component width gives the LSB
  localparam int RE = 0;
  localparam int IM = 1;

  function automatic int ew(input int dw);
    return dw + 1;
  endfunction

  function automatic int ow(input int dw);
    return 2 * dw + 3;
  endfunction

  function automatic int aw(input int dw, input int ml);
`ifdef CMS_ROUND_EN
    return ow(dw) + ml + 1;
`else
    return ow(dw) + ml;
`endif
  endfunction

endpackage

// File: rtl/complex_square_pipe.sv
// Exact complex square e^2 = (er^2 - ei^2) + j(2 er ei), MULT_LAT deep.
// Valid bits flush on i_flush; data regs are free-running.
module complex_square_pipe
  import cms_pkg::*;
#(
  parameter int DW       = 16,
  parameter int MULT_LAT = 3
) (
  input  logic                     i_clk,
  input  logic                     i_arst,
  input  logic                     i_flush,
  input  logic                     i_valid,
  input  logic signed [ew(DW)-1:0] i_er,
  input  logic signed [ew(DW)-1:0] i_ei,
  output logic                     o_valid,
  output logic signed [ow(DW)-1:0] o_sq_re,
  output logic signed [ow(DW)-1:0] o_sq_im
);

  localparam int OW = ow(DW);

  logic signed [OW-1:0] w_er, w_ei, w_re, w_im;
  logic signed [OW-1:0] r_re [MULT_LAT];
  logic signed [OW-1:0] r_im [MULT_LAT];
  logic [MULT_LAT-1:0]  r_v;

  assign w_er = OW'(i_er);
  assign w_ei = OW'(i_ei);
  assign w_re = w_er * w_er - w_ei * w_ei;
  assign w_im = (w_er * w_ei) <<< 1;

  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      r_v <= '0;
    end else if (i_flush) begin
      r_v <= '0;
    end else begin
      r_v[0] <= i_valid;
      for (int k = 1; k < MULT_LAT; k++)
        r_v[k] <= r_v[k-1];
    end
  end

  always_ff @(posedge i_clk) begin
    r_re[0] <= w_re;
    r_im[0] <= w_im;
    for (int k = 1; k < MULT_LAT; k++) begin
      r_re[k] <= r_re[k-1];
      r_im[k] <= r_im[k-1];
    end
  end

  assign o_valid = r_v[MULT_LAT-1];
  assign o_sq_re = r_re[MULT_LAT-1];
  assign o_sq_im = r_im[MULT_LAT-1];

endmodule

// File: rtl/complex_mse_stream.sv
// Streaming complex mean of (y - y_hat)^2 over 2^L samples.
// CMS_ROUND_EN selects round-half-up instead of floor on the divide.
module complex_mse_stream
  import cms_pkg::*;
#(
  parameter int DW       = 16,
  parameter int MAX_LOG2 = 7,
  parameter int MULT_LAT = 3
) (
  input  logic                  i_clk,
  input  logic                  i_arst,
  input  logic                  i_start,
  input  logic                  i_clear,
  input  logic                  i_cont,
  input  logic [3:0]            i_log2_samples,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic [2*DW-1:0]       i_y,
  input  logic [2*DW-1:0]       i_y_hat,
  output logic                  o_valid,
  output logic [2*ow(DW)-1:0]   o_data,
  output logic                  o_busy
);

  localparam int EW = ew(DW);
  localparam int OW = ow(DW);
  localparam int AW = aw(DW, MAX_LOG2);
  localparam int CW = MAX_LOG2 + 1;

  state_t r_state, w_next;
  logic                 w_arm;
  logic [3:0]           r_l, w_l;
  logic                 r_cont;
  logic [CW-1:0]        r_rx, r_proc, w_n;
  logic signed [AW-1:0] r_acc_re, r_acc_im;
  logic signed [AW-1:0] w_half, w_sre, w_sim;
  logic signed [EW-1:0] w_er, w_ei;
  logic                 w_acc_in, w_pv;
  logic signed [OW-1:0] w_sq_re, w_sq_im;

  assign w_er = EW'($signed(i_y[RE*DW +: DW]))
              - EW'($signed(i_y_hat[RE*DW +: DW]));
  assign w_ei = EW'($signed(i_y[IM*DW +: DW]))
              - EW'($signed(i_y_hat[IM*DW +: DW]));

  assign w_l = (i_log2_samples > 4'(MAX_LOG2))
             ? 4'(MAX_LOG2) : i_log2_samples;
  assign w_n      = CW'(1) << r_l;
  assign o_ready  = (r_state == S_RUN) && (r_rx < w_n);
  assign w_acc_in = i_valid && o_ready;
  assign o_busy   = (r_state != S_IDLE);

  complex_square_pipe #(
    .DW      (DW),
    .MULT_LAT(MULT_LAT)
  ) u_sq (
    .i_clk  (i_clk),
    .i_arst (i_arst),
    .i_flush(i_clear),
    .i_valid(w_acc_in),
    .i_er   (w_er),
    .i_ei   (w_ei),
    .o_valid(w_pv),
    .o_sq_re(w_sq_re),
    .o_sq_im(w_sq_im)
  );

  // w_arm: entering RUN with a fresh accumulator and counters
  always_comb begin
    w_next = r_state;
    w_arm  = 1'b0;
    unique case (r_state)
      S_IDLE:  if (i_start) begin
                 w_next = S_RUN;
                 w_arm  = 1'b1;
               end
      S_RUN:   if (r_rx == w_n) w_next = S_DRAIN;
      S_DRAIN: if (r_proc == w_n) w_next = S_DONE;
      S_DONE:  begin
                 w_next = r_cont ? S_RUN : S_IDLE;
                 w_arm  = r_cont;
               end
      default: w_next = S_IDLE;
    endcase
    if (i_clear) begin
      w_next = S_IDLE;
      w_arm  = 1'b0;
    end
  end

  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      r_state  <= S_IDLE;
      r_l      <= '0;
      r_cont   <= 1'b0;
      r_rx     <= '0;
      r_proc   <= '0;
      r_acc_re <= '0;
      r_acc_im <= '0;
    end else begin
      r_state <= w_next;
      if (w_arm && r_state == S_IDLE) begin
        r_l    <= w_l;
        r_cont <= i_cont;
      end
      if (w_arm) begin
        r_rx     <= '0;
        r_proc   <= '0;
        r_acc_re <= '0;
        r_acc_im <= '0;
      end else begin
        if (w_acc_in) r_rx <= r_rx + CW'(1);
        if (w_pv) begin
          r_proc   <= r_proc + CW'(1);
          r_acc_re <= r_acc_re + AW'(w_sq_re);
          r_acc_im <= r_acc_im + AW'(w_sq_im);
        end
      end
    end
  end

`ifdef CMS_ROUND_EN
  assign w_half = (r_l == 4'd0) ? '0 : (AW'(1) <<< (r_l - 4'd1));
`else
  assign w_half = '0;
`endif
  assign w_sre = (r_acc_re + w_half) >>> r_l;
  assign w_sim = (r_acc_im + w_half) >>> r_l;

  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      o_valid <= 1'b0;
      o_data  <= '0;
    end else begin
      o_valid <= (r_state == S_DONE) && !i_clear;
      if (r_state == S_DONE && !i_clear)
        o_data <= {w_sim[OW-1:0], w_sre[OW-1:0]};
    end
  end

endmodule
